// File: rtl/seg7_scan_driver_pkg.sv
// Shared 7-segment definitions: segment bit positions, digit codes, width helper.
package seg7_scan_driver_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  typedef logic [6:0] seg_code_t;

  function automatic seg_code_t seg_lit(input logic a, input logic b, input logic c,
                                        input logic d, input logic e, input logic f,
                                        input logic g);
    seg_code_t r;
    r        = '0;
    r[SEG_A] = a;
    r[SEG_B] = b;
    r[SEG_C] = c;
    r[SEG_D] = d;
    r[SEG_E] = e;
    r[SEG_F] = f;
    r[SEG_G] = g;
    return r;
  endfunction

  localparam seg_code_t SEG_0    = seg_lit(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
  localparam seg_code_t SEG_1    = seg_lit(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  localparam seg_code_t SEG_2    = seg_lit(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
  localparam seg_code_t SEG_3    = seg_lit(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
  localparam seg_code_t SEG_4    = seg_lit(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
  localparam seg_code_t SEG_5    = seg_lit(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
  localparam seg_code_t SEG_6    = seg_lit(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
  localparam seg_code_t SEG_7    = seg_lit(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  localparam seg_code_t SEG_8    = seg_lit(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
  localparam seg_code_t SEG_9    = seg_lit(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
  localparam seg_code_t SEG_DASH = seg_lit(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  localparam seg_code_t SEG_OFF  = '0;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-high 7-segment code; codes 10..15 show a dash.
module bcd_to_seg7
  import seg7_scan_driver_pkg::*;
(
  input  logic [3:0] bcd,
  output seg_code_t  seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit 7-segment scanner with shadow register, blink and polarity.
// Optional leading-zero suppression when LEADING_ZERO_BLANK_EN is defined.
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64,
  parameter int ACTIVE_LOW   = 0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              en,
  input  logic                              load,
  input  logic [4*NUM_DIGITS-1:0]           digits_in,
  input  logic [NUM_DIGITS-1:0]             blink_mask,
  output logic [6:0]                        seg,
  output logic [NUM_DIGITS-1:0]             an,
  output logic [idx_width(NUM_DIGITS)-1:0]  digit_idx
);

  localparam int IW = idx_width(NUM_DIGITS);
  localparam int PW = idx_width(SCAN_DIV);
  localparam int FW = idx_width(BLINK_FRAMES);
  localparam logic [6:0]            SEG_INACT = {7{ACTIVE_LOW != 0}};
  localparam logic [NUM_DIGITS-1:0] AN_INACT  = {NUM_DIGITS{ACTIVE_LOW != 0}};

  logic [4*NUM_DIGITS-1:0] shadow;
  logic [PW-1:0]           presc;
  logic [FW-1:0]           frame_cnt;
  logic                    blink_phase;
  logic [3:0]              cur_bcd;
  logic                    cur_blink;
  logic                    zero_blank;
  seg_code_t               cur_code;
  logic                    blanked;
  logic [6:0]              seg_next;
  logic [NUM_DIGITS-1:0]   an_next;
  logic                    presc_tc;
  logic                    idx_last;
  logic                    frame_last;

  assign presc_tc   = (presc == PW'(SCAN_DIV - 1));
  assign idx_last   = (digit_idx == IW'(NUM_DIGITS - 1));
  assign frame_last = (frame_cnt == FW'(BLINK_FRAMES - 1));

  always_comb begin
    cur_bcd   = '0;
    cur_blink = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (digit_idx == IW'(k)) begin
        cur_bcd   = shadow[4*k +: 4];
        cur_blink = blink_mask[k];
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lz;

  // Walk down from the most significant digit; digit 0 is never suppressed.
  always_comb begin : lz_scan
    logic still_zero;
    lz         = '0;
    still_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      still_zero = still_zero && (shadow[4*k +: 4] == 4'd0);
      lz[k]      = still_zero;
    end
  end

  always_comb begin
    zero_blank = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (digit_idx == IW'(k)) zero_blank = lz[k];
    end
  end
`else
  assign zero_blank = 1'b0;
`endif

  bcd_to_seg7 u_dec (
    .bcd (cur_bcd),
    .seg (cur_code)
  );

  assign blanked  = (blink_phase && cur_blink) || zero_blank;
  assign seg_next = (blanked ? SEG_OFF : cur_code) ^ SEG_INACT;
  assign an_next  = (NUM_DIGITS'(1) << digit_idx) ^ AN_INACT;

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow      <= '0;
      presc       <= '0;
      digit_idx   <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      seg         <= SEG_INACT;
      an          <= AN_INACT;
    end else begin
      if (load) shadow <= digits_in;
      if (en) begin
        seg <= seg_next;
        an  <= an_next;
        if (presc_tc) begin
          presc <= '0;
          if (idx_last) begin
            digit_idx <= '0;
            if (frame_last) begin
              frame_cnt   <= '0;
              blink_phase <= ~blink_phase;
            end else begin
              frame_cnt <= frame_cnt + FW'(1);
            end
          end else begin
            digit_idx <= digit_idx + IW'(1);
          end
        end else begin
          presc <= presc + PW'(1);
        end
      end else begin
        seg <= SEG_INACT;
        an  <= AN_INACT;
      end
    end
  end

endmodule
